// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS control unit: opcodes, ALU codes, FSM states, instruction fields.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mips8_pkg;

    // ALU opcodes live in instr[7:5]; 3'b101 is the branch opcode.
    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_BZ  = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    // The branch opcode doubles as the "no ALU operation" code.
    localparam logic [2:0] ALU_IDLE = 3'b101;

    // Instruction field positions.
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int OFF_MSB = 4;
    localparam int OFF_W   = 5;

    // Controller states.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        BRANCH    = 3'd4,
        HALT      = 3'd5
    } state_t;

endpackage

// File: rtl/mips8_ctrl_fsm.sv
// Multi-cycle control unit: fetches, decodes and sequences 8-bit MIPS instructions, drives ALU/RF control.
// Latency: ALU op = fetch wait + 4 cycles, branch = fetch wait + 3 cycles (ack cycle counted in FETCH).
// Backpressure: FETCH holds imem_req until imem_ack; acks outside a live request are ignored.
module mips8_ctrl_fsm
    import mips8_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [2:0]      alu_control,
    input  logic            alu_zero,
    output logic [1:0]      rf_raddr0,
    output logic [1:0]      rf_raddr1,
    output logic [1:0]      rf_waddr,
    output logic            rf_we,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic            zflag_q, zflag_d;
    logic            imem_req_q, imem_req_d;

    logic [2:0]       op;
    logic [OFF_W-1:0] off;
    logic [PC_W-1:0]  off_ext;

    assign op      = ir_q[OP_MSB:OP_LSB];
    assign off     = ir_q[OFF_MSB:0];
    assign off_ext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};

    // Next-state, PC, IR and zero-flag update; the fetch request is registered so it is low in reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        unique case (state_q)
            FETCH: begin
                if (imem_req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = (op == OP_BZ) ? BRANCH : EXECUTE;
            end
            EXECUTE: begin
                zflag_d = alu_zero;
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                pc_d    = pc_q + PC_INC;
                state_d = FETCH;
            end
            BRANCH: begin
                // A zero offset would loop forever on itself, so it is the halt encoding.
                if (off == '0) begin
                    state_d = HALT;
                end else begin
                    pc_d    = zflag_q ? (pc_q + off_ext) : (pc_q + PC_INC);
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        imem_req_d = (state_d == FETCH);
    end

    // State and datapath-control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            zflag_q    <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            zflag_q    <= zflag_d;
            imem_req_q <= imem_req_d;
        end
    end

    // Outputs decoded from registered state/ir only.
    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign alu_control = (state_q == EXECUTE || state_q == WRITEBACK) ? op : ALU_IDLE;
    assign rf_raddr0   = ir_q[RD_MSB:RD_LSB];
    assign rf_raddr1   = ir_q[RS_MSB:RS_LSB];
    assign rf_waddr    = ir_q[RD_MSB:RD_LSB];
    assign rf_we       = (state_q == WRITEBACK);
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_mips8_ctrl_fsm.sv
// Self-checking bench for mips8_ctrl_fsm: instruction-level reference model feeding a scoreboard.
// Latency: n/a.
// Backpressure: the bench's memory responder inserts random fetch wait states.
module tb_mips8_ctrl_fsm;

    localparam logic [2:0] IDLE = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [2:0] alu_control;
    logic       alu_zero = 1'b0;
    logic [1:0] rf_raddr0, rf_raddr1, rf_waddr;
    logic       rf_we;
    logic [7:0] pc;
    logic       halted;

    mips8_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_control(alu_control), .alu_zero(alu_zero),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] rs;
        logic [2:0] op;
    } wr_t;

    // Scoreboard queues: expected register writes and expected fetch addresses.
    wr_t exp_wr[$];
    int  exp_fetch[$];

    // Instruction-level reference model state.
    int m_pc;
    bit m_z;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_init();
        exp_wr.delete();
        exp_fetch.delete();
        m_pc = 0;
        m_z  = 1'b0;
        exp_fetch.push_back(0);
    endtask

    // Architectural effect of one instruction: ALU ops write rd and step the PC;
    // BZ jumps by the signed offset only if the last ALU result was zero.
    task automatic model_exec(input logic [7:0] ins, input bit z);
        int off;
        if (ins[7:5] != 3'b101) begin
            exp_wr.push_back('{ins[4:3], ins[2:1], ins[7:5]});
            m_z  = z;
            m_pc = (m_pc + 1) % 256;
            exp_fetch.push_back(m_pc);
        end else if (ins[4:0] != 5'd0) begin
            off = int'(ins[4:0]);
            if (off >= 16) off = off - 32;
            m_pc = m_z ? (m_pc + off + 256) % 256 : (m_pc + 1) % 256;
            exp_fetch.push_back(m_pc);
        end
    endtask

    // Immediate asynchronous reset held for one full clock.
    task automatic reset_now();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        model_init();
        #1;
        chk("reset_async_req", imem_req, 1'b0);
        chk("reset_async_we", rf_we, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_now();
    endtask

    // Wait for a fetch request, stall w cycles, then return ins; optionally keep ack up spuriously.
    task automatic do_instr(input logic [7:0] ins, input bit z, input int w, input bit spur);
        int n = 0;
        while (imem_req !== 1'b1) begin
            if (n == 60) begin
                chk("fetch_timeout", 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
            n++;
        end
        repeat (w) @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = ins;
        alu_zero  = z;
        model_exec(ins, z);
        @(negedge clk);
        if (spur) begin
            imem_data = 8'($urandom);
            @(negedge clk);
            imem_data = 8'($urandom);
            @(negedge clk);
        end
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
    endtask

    // Monitor: checks reset values, every fetch address and every register-write pulse.
    logic       req_prev = 1'b0;
    logic [2:0] alu_h1 = IDLE;
    logic [2:0] alu_h2 = IDLE;
    always @(negedge clk) begin
        int  e;
        wr_t w;
        if (!rst_n) begin
            chk("rst_imem_req", imem_req, 1'b0);
            chk("rst_rf_we", rf_we, 1'b0);
            chk("rst_halted", halted, 1'b0);
            chk("rst_alu_control", alu_control, IDLE);
            chk("rst_pc", pc, 8'h00);
            req_prev = 1'b0;
            alu_h1   = IDLE;
            alu_h2   = IDLE;
        end else begin
            if (imem_req && !req_prev) begin
                if (exp_fetch.size() == 0) begin
                    chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_fetch.pop_front();
                    chk("fetch_addr", imem_addr, e);
                    chk("pc_at_fetch", pc, e);
                end
            end
            if (rf_we) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_rf_we", rf_we, 1'b0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("rf_waddr", rf_waddr, w.rd);
                    chk("rf_raddr0", rf_raddr0, w.rd);
                    chk("rf_raddr1", rf_raddr1, w.rs);
                    chk("alu_ctl_writeback", alu_control, w.op);
                    chk("alu_ctl_execute", alu_h1, w.op);
                    chk("alu_ctl_decode_idle", alu_h2, IDLE);
                end
            end
            req_prev = imem_req;
            alu_h2   = alu_h1;
            alu_h1   = alu_control;
        end
    end

    // Stimulus: directed scenarios followed by a randomized instruction stream.
    initial begin
        int         n;
        int         req_cnt;
        logic [7:0] ins;
        logic [7:0] pc_hold;

        model_init();
        do_reset();

        // ADD r1,r2 with two fetch wait states.
        do_instr(8'b001_01_10_0, 1'b0, 2, 1'b0);

        // NOR with zero, then BZ +3 at pc 1 -> 4; again without zero -> 2.
        do_reset();
        do_instr(8'b100_00_01_0, 1'b1, 0, 1'b0);
        do_instr(8'b101_00011, 1'b0, 1, 1'b0);
        do_instr(8'b000_10_11_0, 1'b0, 0, 1'b0);
        do_reset();
        do_instr(8'b100_00_01_0, 1'b0, 0, 1'b0);
        do_instr(8'b101_00011, 1'b1, 0, 1'b0);
        do_instr(8'b000_10_11_0, 1'b0, 0, 1'b0);

        // Backward branch wraps below zero, then an ALU op wraps past the top.
        do_reset();
        do_instr(8'b100_11_00_0, 1'b1, 0, 1'b0);
        do_instr(8'b101_11110, 1'b0, 0, 1'b0);
        do_instr(8'b001_01_01_0, 1'b0, 3, 1'b0);
        do_instr(8'b010_00_00_0, 1'b0, 0, 1'b0);

        // Halt: core stops, no further requests, pc frozen; reset clears it.
        do_reset();
        do_instr(8'b011_10_01_0, 1'b1, 0, 1'b0);
        pc_hold = 8'(m_pc);
        do_instr(8'b101_00000, 1'b0, 1, 1'b0);
        req_cnt = 0;
        repeat (22) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
        end
        chk("halt_halted", halted, 1'b1);
        chk("halt_req_count", req_cnt, 0);
        chk("halt_pc_frozen", pc, pc_hold);
        do_reset();
        chk("halt_cleared", halted, 1'b0);

        // Reset in the middle of WRITEBACK: the write must not happen.
        do_instr(8'b001_11_10_0, 1'b0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wb_reached", rf_we, 1'b1);
        reset_now();

        // Reset while a fetch is waiting for its ack.
        n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait_seen", imem_req, 1'b1);
        @(posedge clk);
        #1;
        reset_now();
        do_instr(8'b110_01_00_0, 1'b1, 1, 1'b0);

        // Randomized stream with random waits and occasional spurious acks.
        for (int i = 0; i < 150; i++) begin
            ins = 8'($urandom);
            if (ins[7:5] == 3'b101 && ins[4:0] == 5'd0) ins[0] = 1'b1;
            do_instr(ins, 1'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        // Drain: the final fetch must appear and no write may remain outstanding.
        n = 0;
        while (imem_req !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_writes", exp_wr.size(), 0);
        chk("drain_fetches", exp_fetch.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
